// File: rtl/round_robin_packet_arbiter.sv
// Round-robin packet arbiter for a shared NoC output resource.
// The winner is picked round-robin among packets. Once a head flit transfers
// without its tail, the grant stays on that requester until its tail transfers.
// The grant is combinational over registered state: pointer, lock owner and FSM.
// Optional build macro ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN adds
// lock_timeout_o, a sticky flag raised after LockTimeoutCycles stalled cycles
// in LOCKED. It is diagnostic only and never alters arbitration.
module round_robin_packet_arbiter #(
    parameter int NumberOfRequesters = 4,
    parameter int LockTimeoutCycles  = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumberOfRequesters-1:0]         request_i,
    input  logic [NumberOfRequesters-1:0]         last_i,
    input  logic                                  ready_i,
    output logic [NumberOfRequesters-1:0]         grant_o,
    output logic                                  grant_valid_o,
    output logic [$clog2(NumberOfRequesters)-1:0] grant_id_o,
    output logic                                  locked_o
`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
    ,
    output logic                                  lock_timeout_o
`endif
);

    localparam int IdW = $clog2(NumberOfRequesters);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Reject configurations outside the supported range at elaboration time.
    if (NumberOfRequesters < 2 || NumberOfRequesters > 32) begin : g_bad_requesters
        $error("round_robin_packet_arbiter: NumberOfRequesters must be 2..32");
    end
    if (LockTimeoutCycles < 2) begin : g_bad_timeout
        $error("round_robin_packet_arbiter: LockTimeoutCycles must be >= 2");
    end

    state_t         state_q, state_d;
    logic [IdW-1:0] pointer_q, pointer_d;
    logic [IdW-1:0] lock_id_q, lock_id_d;

    logic           rr_found;
    logic [IdW-1:0] rr_id;
    logic           transfer;

    // Index that follows id in the ring of requesters.
    function automatic logic [IdW-1:0] next_index(input logic [IdW-1:0] id);
        if (int'(id) == NumberOfRequesters - 1) begin
            return '0;
        end
        return id + IdW'(1);
    endfunction

    // Round-robin search: start at pointer_q, ascend, wrap from N-1 to 0.
    always_comb begin
        int             idx;
        logic [IdW-1:0] idx_id;
        rr_found = 1'b0;
        rr_id    = '0;
        idx      = 0;
        idx_id   = '0;
        for (int k = 0; k < NumberOfRequesters; k++) begin
            idx = int'(pointer_q) + k;
            if (idx >= NumberOfRequesters) begin
                idx = idx - NumberOfRequesters;
            end
            idx_id = idx[IdW-1:0];
            if (!rr_found && request_i[idx_id]) begin
                rr_found = 1'b1;
                rr_id    = idx_id;
            end
        end
    end

    // Grant outputs: the round-robin winner in IDLE, the lock owner in LOCKED.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        locked_o      = (state_q == LOCKED);
        if (state_q == LOCKED) begin
            grant_o[lock_id_q] = 1'b1;
            grant_valid_o      = request_i[lock_id_q];
            grant_id_o         = lock_id_q;
        end else if (rr_found) begin
            grant_o[rr_id] = 1'b1;
            grant_valid_o  = 1'b1;
            grant_id_o     = rr_id;
        end
    end

    assign transfer = grant_valid_o & ready_i;

    // Next-state logic: only a transfer commits a lock, a release or a pointer move.
    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        lock_id_d = lock_id_q;
        if (transfer) begin
            if (state_q == IDLE) begin
                if (last_i[grant_id_o]) begin
                    pointer_d = next_index(grant_id_o);
                end else begin
                    state_d   = LOCKED;
                    lock_id_d = grant_id_o;
                end
            end else if (last_i[lock_id_q]) begin
                state_d   = IDLE;
                pointer_d = next_index(lock_id_q);
            end
        end
    end

    // Arbitration state register; reset drops any lock immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pointer_q <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            lock_id_q <= lock_id_d;
        end
    end

`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
    localparam int CntW = $clog2(LockTimeoutCycles + 1);

    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic            timeout_q;

    // Stall count: grows on each stalled LOCKED cycle, saturates at the limit.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != LOCKED || transfer) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != CntW'(LockTimeoutCycles)) begin
            stall_cnt_d = stall_cnt_q + CntW'(1);
        end
    end

    // Counter and sticky flag; the flag rises on the edge the count hits the limit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_q | (stall_cnt_d == CntW'(LockTimeoutCycles));
        end
    end

    assign lock_timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_round_robin_packet_arbiter.sv
// Directed bench for round_robin_packet_arbiter with four requesters.
// Inputs change 1 ns after a rising edge; outputs are checked on the falling edge.
// Define ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN to cover lock_timeout_o.
module tb_round_robin_packet_arbiter;

    localparam int N = 4;

    logic         clk_i;
    logic         rst_i;
    logic [N-1:0] request_i;
    logic [N-1:0] last_i;
    logic         ready_i;
    logic [N-1:0] grant_o;
    logic         grant_valid_o;
    logic [1:0]   grant_id_o;
    logic         locked_o;
`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
    logic         lock_timeout_o;
`endif

    int checks;
    int errors;

    round_robin_packet_arbiter #(
        .NumberOfRequesters(N),
        .LockTimeoutCycles (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .request_i    (request_i),
        .last_i       (last_i),
        .ready_i      (ready_i),
        .grant_o      (grant_o),
        .grant_valid_o(grant_valid_o),
        .grant_id_o   (grant_id_o),
        .locked_o     (locked_o)
`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
        ,
        .lock_timeout_o(lock_timeout_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] g, input logic v,
                             input logic [1:0] id, input logic lk);
        check_eq({tag, ".grant"}, 32'(grant_o), 32'(g));
        check_eq({tag, ".valid"}, 32'(grant_valid_o), 32'(v));
        check_eq({tag, ".id"}, 32'(grant_id_o), 32'(id));
        check_eq({tag, ".locked"}, 32'(locked_o), 32'(lk));
    endtask

    // Apply one cycle of inputs, then wait for the falling edge to observe.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] lst, input logic rdy);
        @(posedge clk_i);
        #1;
        request_i = req;
        last_i    = lst;
        ready_i   = rdy;
        @(negedge clk_i);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_i     = 1'b1;
        request_i = '0;
        last_i    = '0;
        ready_i   = 1'b0;

        // Reset state
        #3;
        check_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
        check_eq("reset.timeout", 32'(lock_timeout_o), 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;

        // Fairness: all requesting single-flit packets -> 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b1);
            check_eq($sformatf("fair%0d.id", k), 32'(grant_id_o), 32'(k % 4));
            check_eq($sformatf("fair%0d.locked", k), 32'(locked_o), 32'd0);
        end
        // Pointer now 1; a single flit from 3 moves it to 0.
        step(4'b1000, 4'b1111, 1'b1);
        check_out("skip_to3", 4'b1000, 1'b1, 2'd3, 1'b0);

        // Lock: three-flit packet from 0 while 1 also requests
        step(4'b0011, 4'b0000, 1'b1);
        check_out("lock.f1", 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0011, 4'b0000, 1'b1);
        check_out("lock.f2", 4'b0001, 1'b1, 2'd0, 1'b1);
        step(4'b0011, 4'b0001, 1'b1);
        check_out("lock.f3", 4'b0001, 1'b1, 2'd0, 1'b1);
        step(4'b0011, 4'b0011, 1'b1);
        check_out("lock.next", 4'b0010, 1'b1, 2'd1, 1'b0);

        // Backpressure and bubble on requester 2 (pointer now 2)
        step(4'b0110, 4'b0000, 1'b1);
        check_out("bp.head", 4'b0100, 1'b1, 2'd2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'b0110, 4'b0110, 1'b0);
            check_out($sformatf("bp.stall%0d", k), 4'b0100, 1'b1, 2'd2, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            step(4'b0010, 4'b0110, 1'b1);
            check_out($sformatf("bp.bubble%0d", k), 4'b0100, 1'b0, 2'd2, 1'b1);
        end
        step(4'b0110, 4'b0100, 1'b1);
        check_out("bp.tail", 4'b0100, 1'b1, 2'd2, 1'b1);

        // Wrap and skip: pointer 3, requests 0 and 2 -> 0 wins, then 2
        step(4'b0101, 4'b0000, 1'b1);
        check_out("wrap.head", 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0101, 4'b0001, 1'b1);
        check_out("wrap.tail", 4'b0001, 1'b1, 2'd0, 1'b1);
        step(4'b0101, 4'b0101, 1'b1);
        check_out("wrap.next", 4'b0100, 1'b1, 2'd2, 1'b0);

        // Reset mid-packet while LOCKED on 3 (pointer now 3)
        step(4'b1000, 4'b0000, 1'b1);
        check_out("rst.head", 4'b1000, 1'b1, 2'd3, 1'b0);
        step(4'b0000, 4'b0000, 1'b1);
        check_out("rst.bubble", 4'b1000, 1'b0, 2'd3, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check_out("rst.async", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        step(4'b1001, 4'b0000, 1'b0);
        check_out("rst.ptr0", 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b1000, 4'b1000, 1'b1);
        check_out("rst.req3", 4'b1000, 1'b1, 2'd3, 1'b0);

        // Long stall in LOCKED on requester 1 (pointer now 0)
        step(4'b0010, 4'b0000, 1'b1);
        check_out("wd.head", 4'b0010, 1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(4'b0011, 4'b0011, 1'b0);
            check_eq($sformatf("wd.stall%0d.grant", k), 32'(grant_o), 32'(4'b0010));
`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
            check_eq($sformatf("wd.stall%0d.timeout", k), 32'(lock_timeout_o), 32'd0);
`endif
        end
        step(4'b0010, 4'b0010, 1'b1);
        check_out("wd.tail", 4'b0010, 1'b1, 2'd1, 1'b1);
`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
        check_eq("wd.raised", 32'(lock_timeout_o), 32'd1);
`endif
        step(4'b0000, 4'b0000, 1'b0);
        check_out("wd.idle", 4'b0000, 1'b0, 2'd0, 1'b0);
`ifdef ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN
        check_eq("wd.sticky", 32'(lock_timeout_o), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_robin_packet_arbiter.md
Name: round_robin_packet_arbiter

Overview:
- Shares one NoC output resource (router output port / link) among NumberOfRequesters input streams at packet granularity.
- Round-robin choice between packets; once a head flit is accepted, the grant stays locked to that requester until its tail flit transfers.
- Fair companion to the fixed-priority-with-hold arbiter used in router allocators.
- Zero-latency combinational grant over registered state (pointer, lock, FSM).

Parameters:
- NumberOfRequesters, 4, number of requesters; legal range 2..32.
- LockTimeoutCycles, 1024, stall-cycle limit for the watchdog; used only with the optional feature; must be >= 2.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- request_i  input  NumberOfRequesters  bit i: requester i has a valid flit.
- last_i  input  NumberOfRequesters  bit i: requester i's current flit is a tail; sampled only on a transfer.
- ready_i  input  1  output resource accepts a flit this cycle.
- grant_o  output  NumberOfRequesters  one-hot or zero; selects the requester.
- grant_valid_o  output  1  the granted requester presents a flit.
- grant_id_o  output  $clog2(NumberOfRequesters)  binary index of grant_o; 0 when grant_o is zero.
- locked_o  output  1  FSM is in LOCKED.

Behaviour:
- Reset (async, active-high): state=IDLE, pointer_q=0, lock_id_q=0, locked_o=0. Outputs after reset with request_i=0: grant_o=0, grant_valid_o=0, grant_id_o=0.
- Transfer: grant_valid_o & ready_i in a given cycle. All state updates happen on the rising clock edge after a transfer. No transfer means no state change, except the watchdog.
- IDLE state:
  - grant_o is a round-robin pick over request_i. Search starts at index pointer_q, ascends, and wraps from N-1 to 0.
  - grant_valid_o = |request_i.
  - No requests: grant_o=0.
- IDLE, on transfer with last_i[winner]=1: single-flit packet. Stay in IDLE; pointer_q <= (winner+1) mod N.
- IDLE, on transfer with last_i[winner]=0:
  - Go to LOCKED; lock_id_q <= winner.
  - pointer_q is unchanged until the tail transfers.
- LOCKED state:
  - grant_o = onehot(lock_id_q), regardless of other requests.
  - grant_valid_o = request_i[lock_id_q].
  - If the owner drops its request, the output is a bubble: grant_o stays asserted, grant_valid_o=0, and the lock is held.
- LOCKED, on transfer with last_i[lock_id_q]=1: go to IDLE; pointer_q <= (lock_id_q+1) mod N.
- Changing request_i or last_i while ready_i=0 never moves the grant in LOCKED. In IDLE the grant may change, since nothing has been committed yet.
- ready_i=1 with grant_valid_o=0 is not a transfer.
- Wrap: pointer at N-1 plus a tail from N-1 sets pointer_q to 0.
- Reset asserted mid-packet: the lock is dropped immediately (async). Requesters must restart their packets.
- grant_o and grant_id_o are always consistent in the same cycle.

Optional Feature:
- Macro: ROUND_ROBIN_PACKET_ARBITER_LOCK_WATCHDOG_EN.
- With the macro defined:
  - Adds output lock_timeout_o (1 bit) and a stall counter of width $clog2(LockTimeoutCycles+1).
  - Counter reset value is 0. It increments each cycle in LOCKED with no transfer, and clears on any transfer or on entering IDLE.
  - When the counter reaches LockTimeoutCycles, lock_timeout_o is set. It is sticky until rst_i.
  - Arbitration is not altered; the watchdog is diagnostic only.
- Without the macro: no port, no counter; behaviour is otherwise identical.

Test Plan (N=4):
- Fairness: request_i=4'b1111 held, all last_i=1, ready_i=1 -> grant_id_o sequence 0,1,2,3,0 on consecutive cycles; locked_o stays 0.
- Lock: req0 sends a 3-flit packet (last on 3rd) while request_i=4'b0011 -> grant_o=4'b0001 for 3 transfers, locked_o=1 during flits 2-3; next grant_id_o=1.
- Backpressure and bubble: in LOCKED on requester 2, ready_i=0 for 5 cycles, then request_i[2]=0 for 2 cycles while req1 is asserted -> grant_o stays 4'b0100, grant_valid_o=0 during the bubble, no grant to 1.
- Wrap and skip: pointer_q=3, request_i=4'b0101 -> grant_id_o=0. After its tail transfers, pointer_q=1 and the next grant_id_o=2.
- Reset mid-packet: assert rst_i while LOCKED on 3 -> locked_o=0, grant_o=0 asynchronously. After release with request_i=4'b1000 -> grant_id_o=3, pointer-based from 0.
- Watchdog (macro on, LockTimeoutCycles=8): LOCKED with ready_i=0 for 8 cycles -> lock_timeout_o rises after the 8th stall and stays 1 after the tail transfers.
